vec_driver: RTL
===============

VEC_DRIVER -- requirements
Module: vec_driver

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the cycles between driving a vector and sampling the response (legal range 1..15).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, with asynchronous active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit, a pulse that begins a 16-vector sweep.
REQ-005 The block SHALL have the ports x1, x2, x3, x4, output, 1 bit each, the vector driven to the 4-input detector; x1 is MSB of the vector index.
REQ-006 The block SHALL have the port vec_valid, output, 1 bit, high while x1..x4 hold a vector under test.
REQ-007 The block SHALL have the port resp, input, 1 bit, the detector output.
REQ-008 The block SHALL have the port busy, output, 1 bit, high from sweep start until done.
REQ-009 The block SHALL have the port done, output, 1 bit, a one-cycle pulse when the sweep completes.
REQ-010 The block SHALL have the port pass_cnt, output, 5 bits, the count of vectors whose response matched.
REQ-011 The block SHALL have the port err_cnt, output, 5 bits, the count of vectors whose response mismatched.
REQ-012 The block SHALL have the port first_err, output, 4 bits, the index of the first mismatching vector.
REQ-013 The block SHALL have the port err_seen, output, 1 bit, high once any mismatch is recorded in the current sweep.

Function
REQ-014 The expected response SHALL be 1 when exactly one of x1..x4 is 1 (index 1, 2, 4, 8) and 0 otherwise.
REQ-015 The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-016 In IDLE with start=1, the block SHALL clear pass_cnt, err_cnt, first_err and err_seen, set the index to 0, and go to DRIVE next cycle.
REQ-017 In DRIVE, the block SHALL put the index on x1..x4, assert vec_valid, load the settle counter with SETTLE-1, and go to WAIT.
REQ-018 In WAIT, the block SHALL decrement the settle counter and go to CHECK when it reads 0, so resp is sampled exactly SETTLE cycles after x1..x4 change.
REQ-019 In CHECK, on a match the block SHALL increment pass_cnt.
REQ-020 In CHECK, on a mismatch the block SHALL increment err_cnt, and if err_seen=0 it SHALL load first_err with the index and set err_seen.
REQ-021 In CHECK, if index=15 the block SHALL go to DONE; otherwise it SHALL increment the index and return to DRIVE.
REQ-022 In DONE, the block SHALL pulse done for one cycle, deassert busy and vec_valid, and return to IDLE.
REQ-023 x1..x4 SHALL hold their last value after a sweep; vec_valid is low outside DRIVE/WAIT/CHECK.
REQ-024 busy SHALL be high in DRIVE, WAIT and CHECK, and in the cycle following start acceptance.
REQ-025 start while busy SHALL be ignored, with no restart and no counter clear.
REQ-026 A start coincident with done SHALL be ignored; a new sweep needs start in IDLE.
REQ-027 pass_cnt + err_cnt SHALL equal 16 at done; counters SHALL NOT wrap, because 5 bits cover 16.
REQ-028 The result outputs SHALL stay stable from done until the next accepted start.
REQ-029 The index SHALL never exceed 15; the increment after 15 does not occur.

Reset
REQ-030 On rst_n=0, asynchronously: the FSM SHALL go to IDLE; x1..x4, vec_valid, busy, done, pass_cnt, err_cnt, first_err, err_seen, the index and the settle counter SHALL be 0.
REQ-031 Reset asserted mid-sweep SHALL abort it with no done pulse; after release the block SHALL wait in IDLE for start.
REQ-032 The first accepted start SHALL be no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-033 Ideal detector model, SETTLE=2, start pulse -> 16 vectors 0..15 in order, done after 16*(SETTLE+2)+1 cycles, pass_cnt=16, err_cnt=0, err_seen=0.
REQ-034 Detector tied resp=0 -> err_cnt=4, pass_cnt=12, first_err=1, err_seen=1.
REQ-035 Detector tied resp=1 -> err_cnt=12, pass_cnt=4, first_err=0.
REQ-036 Detector model delayed 3 cycles with SETTLE=2 -> mismatches occur; with SETTLE=4 -> pass_cnt=16.
REQ-037 start re-pulsed at vector 5, then rst_n low at vector 9 -> the sweep is unaffected by the re-pulse; the reset zeroes all outputs immediately with no done; a fresh start runs a full clean sweep.
REQ-038 Two back-to-back sweeps, the first with a faulty detector and the second ideal -> the second sweep reports err_cnt=0, err_seen=0, and first_err cleared to 0.

Source files
------------

// File: rtl/vec_driver.sv
// rtl/vec_driver.sv - exhaustive 16-vector sweep driver and checker for a 4-input one-hot detector
//
// Drives every 4-bit vector (x1 = MSB) to a detector, waits SETTLE cycles,
// samples the detector response and tallies matches against the ideal
// "exactly one input high" function.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse in IDLE to begin a sweep
//   x1..x4     out  vector under test (held after the sweep)
//   vec_valid  out  high while x1..x4 carry a vector under test
//   resp       in   detector output
//   busy       out  sweep in progress
//   done       out  one-cycle pulse at sweep completion
//   pass_cnt   out  matching vectors
//   err_cnt    out  mismatching vectors
//   first_err  out  index of the first mismatching vector
//   err_seen   out  any mismatch recorded in this sweep

module vec_driver #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       x4,
    output logic       vec_valid,
    input  logic       resp,
    output logic       busy,
    output logic       done,
    output logic [4:0] pass_cnt,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err,
    output logic       err_seen
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] settle;
    logic       match;
    logic       expected;

    // The vector on x1..x4 always equals idx while in WAIT, so the ideal
    // response can be derived from idx directly.
    always_comb begin
        expected = 1'b0;
        case (idx)
            4'd1, 4'd2, 4'd4, 4'd8: expected = 1'b1;
            default:                expected = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            settle    <= 4'd0;
            match     <= 1'b0;
            x1        <= 1'b0;
            x2        <= 1'b0;
            x3        <= 1'b0;
            x4        <= 1'b0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= 5'd0;
            err_cnt   <= 5'd0;
            first_err <= 4'd0;
            err_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pass_cnt  <= 5'd0;
                        err_cnt   <= 5'd0;
                        first_err <= 4'd0;
                        err_seen  <= 1'b0;
                        idx       <= 4'd0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    {x1, x2, x3, x4} <= idx;
                    vec_valid        <= 1'b1;
                    settle           <= SETTLE_LOAD;
                    state            <= WAIT;
                end
                WAIT: begin
                    // resp is captured on the SETTLE-th edge after x1..x4
                    // changed; CHECK then only does the bookkeeping.
                    if (settle == 4'd0) begin
                        match <= (resp == expected);
                        state <= CHECK;
                    end else begin
                        settle <= settle - 4'd1;
                    end
                end
                CHECK: begin
                    if (match) begin
                        pass_cnt <= pass_cnt + 5'd1;
                    end else begin
                        err_cnt <= err_cnt + 5'd1;
                        if (!err_seen) begin
                            first_err <= idx;
                            err_seen  <= 1'b1;
                        end
                    end
                    if (idx == 4'd15) begin
                        // done, busy and vec_valid are registered, so they
                        // change together as the FSM enters DONE.
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        vec_valid <= 1'b0;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
